fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch sequencer for the word-indexed combinational instruction ROM (imem).
//  - Owns the PC and drives it to imem; captures {pc, instruction} into a small prefetch queue.
//  - Presents queued instructions to decode over a valid/ready handshake.
//  - Handles start, branch/jump redirects with flush, and end-of-program drain/halt.
// PARAMETERS
//  N      32    data/PC width; matches imem N
//  INS    1000  ROM depth in words; legal PC range 0..INS-1
//  DEPTH  4     prefetch queue entries (>=2)
// PORTS
//  clk                clock; all state changes on rising edge
//  reset              in   1  synchronous, active-high
//  start              in   1  1-cycle pulse; begin fetching at PC 0
//  imem_pc            out  N  PC to imem (word index, +1 per instruction)
//  imem_instruction   in   N  imem read data for imem_pc (same cycle)
//  redirect_valid     in   1  branch/jump taken; flush and refetch
//  redirect_pc        in   N  new PC (word index)
//  fetch_valid        out  1  queue head valid for decode
//  fetch_ready        in   1  decode accepts head
//  fetch_instruction  out  N  head instruction
//  fetch_pc           out  N  head PC
//  busy               out  1  state is FETCH or DRAIN
//  halted             out  1  state is HALTED
// BEHAVIOUR
//  Reset: state=IDLE, pc=0, queue empty; imem_pc=0, fetch_valid=0, busy=0, halted=0, fetch_* = 0.
//  FSM states: IDLE, FETCH, DRAIN, HALTED.
//   - IDLE:   start -> FETCH with pc=0.
//   - FETCH:  each cycle with queue not full, push {pc, imem_instruction} and set pc<=pc+1.
//             When the pushed pc == INS-1 -> DRAIN.
//   - DRAIN:  no pushes; queue empty -> HALTED.
//   - HALTED: start -> FETCH with pc=0 and queue empty.
//  Full queue: no push, even if a pop happens the same cycle. No comb. ready->push path;
//   imem_pc holds.
//  Pop: fetch_valid = !empty && !redirect_valid; head advances when fetch_valid && fetch_ready.
//  Redirect (any non-IDLE state): highest priority over push, pop and start.
//   - Same cycle: fetch_valid is forced to 0 and no push occurs.
//   - Next edge: queue cleared, pc <= redirect_pc.
//   - redirect_pc < INS -> FETCH. redirect_pc >= INS -> DRAIN, so HALTED one cycle later.
//   - Redirect in IDLE is ignored.
//  start while FETCH/DRAIN is ignored.
//  Latency: start at cycle t -> first push at t+1 -> fetch_valid at t+2.
//   Redirect at t -> first new push at t+1 -> fetch_valid at t+2.
//   Throughput 1 instr/cycle while not full.
//  PC arithmetic: N-bit unsigned. Compare pc against INS-1 before increment, so pc never
//   reads imem beyond INS-1.
//  imem_pc = pc in all states; the read value is ignored unless pushing.
//  Queue order is strict FIFO. pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).
//  Reset mid-operation: returns to reset values on the next edge regardless of handshake or redirect.
// STRUCTURE
//  fetch_pkg:
//   - fetch_state_t enum {IDLE, FETCH, DRAIN, HALTED}
//   - fetch_entry_t struct {pc, instruction} (N-parameterised)
//  Sub-module fetch_queue:
//   - sync FIFO of fetch_entry_t, DEPTH deep
//   - inputs: push, pop, flush; outputs: full, empty, head
//   - flush has priority over push/pop
//  Top level: FSM, PC register, handshake gating.
// TESTING
//  1. ROM[0..3]=A,B,C,D; start at t, ready=1 -> fetch_valid from t+2; pcs 0,1,2,3 with A..D,
//     one per cycle.
//  2. ready=0 after start -> queue fills with 4 entries, imem_pc holds at 4, fetch_pc stays 0.
//     Then ready=1 -> pcs 0..7 in order, no gaps/dupes.
//  3. Queue holds pcs 5,6,7; redirect_pc=100 -> fetch_valid=0 that cycle.
//     Two cycles later fetch_pc=100; pcs 5..7 never accepted.
//  4. INS=8, ready=1 -> last delivered pc=7, busy drops and halted=1 the cycle after it pops.
//     start -> refetch from pc 0.
//  5. redirect_pc=INS+3 -> queue flushed, DRAIN then HALTED next cycle, no further pushes.
//  6. reset asserted mid-stream with 3 entries queued and redirect_valid=1 -> next cycle
//     all outputs at reset values, state IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states and the
// {pc, instruction} record held in the prefetch queue.
package fetch_pkg;

    localparam int FETCH_N = 32;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [FETCH_N-1:0] pc;
        logic [FETCH_N-1:0] instruction;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous prefetch FIFO of {pc, instruction} records.
// Flush has priority over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  entry_t                       din,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output entry_t                       head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    entry_t        mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fills the prefetch queue from the
// combinational imem and hands entries to decode over valid/ready.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int N     = 32,
    parameter int INS   = 1000,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    output logic [N-1:0] imem_pc,
    input  logic [N-1:0] imem_instruction,
    input  logic         redirect_valid,
    input  logic [N-1:0] redirect_pc,
    output logic         fetch_valid,
    input  logic         fetch_ready,
    output logic [N-1:0] fetch_instruction,
    output logic [N-1:0] fetch_pc,
    output logic         busy,
    output logic         halted
);

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] instruction;
    } entry_t;

    localparam int           CW       = $clog2(DEPTH + 1);
    localparam logic [N-1:0] LAST_PC  = N'(INS - 1);
    localparam logic [N-1:0] PC_LIMIT = N'(INS);

    fetch_state_t  state;
    logic [N-1:0]  pc;
    logic          redirect;
    logic          push;
    logic          pop;
    logic          flush;
    logic          drained;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    entry_t        push_entry;
    entry_t        head;

    assign redirect    = redirect_valid && (state != IDLE);
    assign push        = (state == FETCH) && !q_full && !redirect_valid;
    assign fetch_valid = !q_empty && !redirect_valid;
    assign pop         = fetch_valid && fetch_ready;
    assign flush       = redirect || ((state == HALTED) && start);
    // DRAIN never pushes, so the queue is empty after this edge when this holds.
    assign drained     = q_empty || ((q_count == CW'(1)) && pop);
    assign push_entry  = '{pc: pc, instruction: imem_instruction};

    fetch_queue #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
        end else if (redirect) begin
            pc    <= redirect_pc;
            state <= (redirect_pc < PC_LIMIT) ? FETCH : DRAIN;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state <= FETCH;
                        pc    <= '0;
                    end
                end
                FETCH: begin
                    // The last word stays on imem_pc so nothing past the ROM is ever addressed.
                    if (push) begin
                        if (pc == LAST_PC) begin
                            state <= DRAIN;
                        end else begin
                            pc <= pc + N'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (drained) begin
                        state <= HALTED;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem_pc           = pc;
    assign fetch_pc          = q_empty ? '0 : head.pc;
    assign fetch_instruction = q_empty ? '0 : head.instruction;
    assign busy              = (state == FETCH) || (state == DRAIN);
    assign halted            = (state == HALTED);

endmodule
